// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared opcode/function constants, the fetch-stage state
//                encoding and the default reset PC for the MIPS core.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    // Primary opcodes (instr[31:26]) and R-type function codes (instr[5:0])
    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_HALT  = 6'd63;
    localparam logic [5:0] FUNC_JR  = 6'd8;

    // PC loaded out of reset unless the instance overrides it
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Fetch-stage state encoding
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } fetch_state_e;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/next_pc_logic.sv
`default_nettype none
// ============================================================================
//  Module      : next_pc_logic
//  Description : Combinational next-PC target selection for the fetch stage.
//                Priority: JR > J/JAL > taken branch > sequential (pc+4).
//                Halt is handled by the caller, it never reaches here.
//  Ports       : pc_plus4_i    - address of the following instruction
//                instr_i       - instruction being executed
//                rs_data_i     - register rs value (JR target)
//                branch_i      - branch instruction decoded
//                branch_cond_i - ALU compare result, 1 = taken
//                jump_i        - J, JAL or JR decoded
//                target_o      - selected target, before alignment
//                misaligned_o  - target_o[1:0] non-zero
//  Revision    : 1.0 - initial release
// ============================================================================
module next_pc_logic
    import mips_pkg::*;
(
    input  logic [31:0] pc_plus4_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] rs_data_i,
    input  logic        branch_i,
    input  logic        branch_cond_i,
    input  logic        jump_i,
    output logic [31:0] target_o,
    output logic        misaligned_o
);

    logic        w_is_jr;
    logic [31:0] w_branch_off;

    assign w_is_jr      = (instr_i[31:26] == OP_RTYPE) && (instr_i[5:0] == FUNC_JR);
    // Sign-extended word offset, already shifted to a byte offset
    assign w_branch_off = {{14{instr_i[15]}}, instr_i[15:0], 2'b00};

    always_comb begin
        target_o = pc_plus4_i;
        if (jump_i && w_is_jr) begin
            target_o = rs_data_i;
        end else if (jump_i) begin
            target_o = {pc_plus4_i[31:28], instr_i[25:0], 2'b00};
        end else if (branch_i && branch_cond_i) begin
            target_o = pc_plus4_i + w_branch_off;
        end
    end

    // Only a register-sourced target (JR) can actually carry low bits
    assign misaligned_o = |target_o[1:0];

endmodule : next_pc_logic
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction-fetch / next-PC stage of the single-cycle MIPS
//                core. Fetches one instruction per step over a req/ready
//                memory handshake, strobes it to decode for one cycle, then
//                loads the next PC. HALT stops the stage until reset.
//  Ports       : clk, rst                 - clock, synchronous active-high reset
//                imem_req/addr/ready/rdata - instruction memory handshake
//                instr, instr_valid        - instruction and execute strobe
//                pc, pc_plus4              - current PC and pc+4 (JAL link)
//                branch, branch_cond, jump, done, rs_data - control/ALU inputs
//                halted, pc_misalign       - sticky status flags
//                retired                   - executed-instruction counter
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ready,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      instr,
    output logic             instr_valid,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    input  logic             branch,
    input  logic             branch_cond,
    input  logic             jump,
    input  logic             done,
    input  logic [31:0]      rs_data,
    output logic             halted,
    output logic             pc_misalign,
    output logic [CNT_W-1:0] retired
);

    fetch_state_e     state_q;
    logic [31:0]      pc_q;
    logic [31:0]      instr_q;
    logic             halted_q;
    logic             misalign_q;
    logic [CNT_W-1:0] retired_q;

    logic [31:0]      target_d;
    logic             target_mis_d;

    next_pc_logic u_next_pc (
        .pc_plus4_i    (pc_plus4),
        .instr_i       (instr_q),
        .rs_data_i     (rs_data),
        .branch_i      (branch),
        .branch_cond_i (branch_cond),
        .jump_i        (jump),
        .target_o      (target_d),
        .misaligned_o  (target_mis_d)
    );

    // Request is masked by rst so a response racing a reset is never taken
    assign imem_req    = (state_q == S_FETCH) && !rst;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = (state_q == S_EXEC);
    assign pc          = pc_q;
    assign pc_plus4    = pc_q + 32'd4;
    assign halted      = halted_q;
    assign pc_misalign = misalign_q;
    assign retired     = retired_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            instr_q    <= 32'd0;
            halted_q   <= 1'b0;
            misalign_q <= 1'b0;
            retired_q  <= '0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (imem_ready) begin
                        instr_q <= imem_rdata;
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    retired_q <= retired_q + CNT_W'(1);
                    if (done) begin
                        halted_q <= 1'b1;
                        state_q  <= S_HALT;
                    end else begin
                        // Low bits are dropped, the error is only flagged
                        pc_q <= target_d & 32'hFFFF_FFFC;
                        if (target_mis_d) begin
                            misalign_q <= 1'b1;
                        end
                        state_q <= S_FETCH;
                    end
                end
                S_HALT: begin
                    state_q <= S_HALT;
                end
                default: begin
                    state_q <= S_FETCH;
                end
            endcase
        end
    end

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit. Each executed
//                instruction's fetch address and word are queued when the
//                memory response is driven and compared at the execute strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        branch;
    logic        branch_cond;
    logic        jump;
    logic        done;
    logic [31:0] rs_data;
    logic        halted;
    logic        pc_misalign;
    logic [31:0] retired;

    int          err_cnt = 0;
    int          chk_cnt = 0;
    logic [31:0] m_pc;
    logic [31:0] m_ret;
    logic [63:0] sb_q[$];

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .CNT_W    (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .branch      (branch),
        .branch_cond (branch_cond),
        .jump        (jump),
        .done        (done),
        .rs_data     (rs_data),
        .halted      (halted),
        .pc_misalign (pc_misalign),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "simulation timeout");
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic clr_ctrl();
        branch      = 1'b0;
        branch_cond = 1'b0;
        jump        = 1'b0;
        done        = 1'b0;
        rs_data     = 32'd0;
    endtask

    // Reset for one cycle with a live memory response to prove it is ignored
    task automatic do_reset();
        rst        = 1'b1;
        imem_ready = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        #1;
        chk("rst_req_low", imem_req, 1'b0);
        @(posedge clk); #1;
        rst        = 1'b0;
        imem_ready = 1'b0;
        #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_misalign", pc_misalign, 1'b0);
        chk("rst_retired", retired, 32'h0);
        chk("rst_req", imem_req, 1'b1);
        m_pc  = 32'h0;
        m_ret = 32'h0;
    endtask

    // One fetch/execute step; exp_next is the hand-derived next fetch address
    task automatic run_instr(input logic [31:0] rdata, input int wait_n,
                             input logic br, input logic cond, input logic jmp,
                             input logic dn, input logic [31:0] rs,
                             input logic [31:0] exp_next, input logic exp_mis);
        logic [63:0] sb_e;
        int          n;
        chk("fetch_req", imem_req, 1'b1);
        chk("fetch_addr", imem_addr, m_pc);
        for (int i = 0; i < wait_n; i++) begin
            imem_ready = 1'b0;
            @(posedge clk); #1;
            chk("hold_addr", imem_addr, m_pc);
            chk("hold_valid", instr_valid, 1'b0);
            chk("hold_retired", retired, m_ret);
        end
        sb_q.push_back({m_pc, rdata});
        imem_rdata  = rdata;
        imem_ready  = 1'b1;
        branch      = br;
        branch_cond = cond;
        jump        = jmp;
        done        = dn;
        rs_data     = rs;
        @(posedge clk); #1;
        imem_ready = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        n = 0;
        while (!instr_valid && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        if (!instr_valid) begin
            chk("exec_timeout", 1'b0, 1'b1);
            void'(sb_q.pop_front());
        end else begin
            sb_e = sb_q.pop_front();
            chk("exec_latency", n, 0);
            chk("exec_instr", instr, {32'h0, sb_e[31:0]});
            chk("exec_pc", pc, {32'h0, sb_e[63:32]});
            chk("pc_plus4", pc_plus4, {32'h0, sb_e[63:32] + 32'd4});
            chk("exec_req", imem_req, 1'b0);
        end
        @(posedge clk); #1;
        clr_ctrl();
        m_ret = m_ret + 32'd1;
        chk("retired", retired, m_ret);
        chk("instr_valid_pulse", instr_valid, 1'b0);
        if (dn) begin
            chk("halted", halted, 1'b1);
            chk("halt_req", imem_req, 1'b0);
            chk("halt_pc", pc, m_pc);
        end else begin
            chk("next_addr", imem_addr, exp_next);
            chk("misalign", pc_misalign, exp_mis);
            chk("not_halted", halted, 1'b0);
            m_pc = exp_next;
        end
    endtask

    initial begin
        clr_ctrl();
        imem_ready = 1'b0;
        imem_rdata = 32'h0;
        rst        = 1'b1;
        @(posedge clk); #1;
        do_reset();

        // Plain ADDI, ready in the first fetch cycle
        run_instr(32'h2008_0005, 0, 0, 0, 0, 0, 32'h0, 32'h0000_0004, 1'b0);
        // JR to 0x10, then BEQ -2 taken -> 0x14-8
        run_instr(32'h03E0_0008, 0, 0, 0, 1, 0, 32'h0000_0010, 32'h0000_0010, 1'b0);
        run_instr(32'h1109_FFFE, 0, 1, 1, 0, 0, 32'h0, 32'h0000_000C, 1'b0);
        // Back to 0x10, same BEQ not taken
        run_instr(32'h03E0_0008, 0, 0, 0, 1, 0, 32'h0000_0010, 32'h0000_0010, 1'b0);
        run_instr(32'h1109_FFFE, 0, 1, 0, 0, 0, 32'h0, 32'h0000_0014, 1'b0);
        // J in the 0x4xxxxxxx region, alone and with a taken branch
        run_instr(32'h03E0_0008, 0, 0, 0, 1, 0, 32'h4000_0010, 32'h4000_0010, 1'b0);
        run_instr(32'h0800_0100, 0, 0, 0, 1, 0, 32'h0, 32'h4000_0400, 1'b0);
        run_instr(32'h03E0_0008, 0, 0, 0, 1, 0, 32'h4000_0010, 32'h4000_0010, 1'b0);
        run_instr(32'h0800_0100, 0, 1, 1, 1, 0, 32'h0, 32'h4000_0400, 1'b0);
        // Three wait cycles before ready
        run_instr(32'h0000_0000, 3, 0, 0, 0, 0, 32'h0, 32'h4000_0404, 1'b0);
        // Sequential wrap at the top of the address space
        run_instr(32'h03E0_0008, 0, 0, 0, 1, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0);
        run_instr(32'h0000_0000, 1, 0, 0, 0, 0, 32'h0, 32'h0000_0000, 1'b0);
        // Misaligned JR target, flag stays set afterwards
        run_instr(32'h03E0_0008, 0, 0, 0, 1, 0, 32'h0000_0123, 32'h0000_0120, 1'b1);
        run_instr(32'h0000_0000, 0, 0, 0, 0, 0, 32'h0, 32'h0000_0124, 1'b1);
        // HALT with a jump also asserted: done has priority
        run_instr(32'hFC00_0000, 0, 0, 0, 1, 1, 32'h0000_0800, 32'h0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            imem_ready = i[0];
            @(posedge clk); #1;
            chk("halt_req_hold", imem_req, 1'b0);
            chk("halt_valid_hold", instr_valid, 1'b0);
            chk("halt_pc_hold", pc, 32'h0000_0124);
            chk("halt_retired_hold", retired, m_ret);
            chk("halt_sticky", halted, 1'b1);
        end
        imem_ready = 1'b0;

        // Reset clears the halt and fetch resumes at RESET_PC
        do_reset();
        run_instr(32'h2008_0005, 1, 0, 0, 0, 0, 32'h0, 32'h0000_0004, 1'b0);
        chk("sb_empty", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule : tb_fetch_unit
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch and next-PC stage of the single-cycle MIPS core, directly upstream of control_unit.
- Holds the PC and fetches one instruction per step from a variable-latency instruction memory using a req/ready handshake.
- Presents the instruction to decode and computes the next PC from the branch/jump/done signals that control_unit and the ALU return.
- Stops permanently on HALT (opcode 63, control_unit `done`) until reset.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  instruction-memory request.
- imem_addr  out  32  fetch address; equals pc.
- imem_ready  in  1  memory response valid; imem_rdata is valid in the same cycle.
- imem_rdata  in  32  fetched instruction word.
- instr  out  32  latched instruction, driven to decode.
- instr_valid  out  1  one-cycle execute strobe.
- pc  out  32  current PC.
- pc_plus4  out  32  pc+4; this is the JAL link value when reg_dst=2.
- branch  in  1  from control_unit.
- branch_cond  in  1  ALU compare result; 1 means taken.
- jump  in  1  from control_unit; asserted for J, JAL and JR.
- done  in  1  from control_unit (HALT).
- rs_data  in  32  register-file rs value, used as the JR target.
- halted  out  1  sticky halt indication.
- pc_misalign  out  1  sticky; set when a computed target had bits [1:0] non-zero.
- retired  out  CNT_W  count of executed instructions.

Behaviour:
- FSM states: S_FETCH, S_EXEC, S_HALT. All state, pc, instr, halted, pc_misalign and retired are registered.
- Reset:
  - state=S_FETCH, pc=RESET_PC, instr=0, halted=0, pc_misalign=0, retired=0.
  - imem_req is forced to 0 in any cycle where rst=1.
- S_FETCH:
  - imem_req=1, imem_addr=pc, instr_valid=0.
  - imem_ready=0: hold; pc and imem_addr stay stable.
  - imem_ready=1: instr<=imem_rdata, then go to S_EXEC.
  - imem_ready is ignored in every other state.
- S_EXEC:
  - imem_req=0 and instr_valid=1 for exactly one cycle.
  - branch, branch_cond, jump, done and rs_data are sampled in this cycle. Downstream combinational logic settles within the cycle.
  - retired<=retired+1 on every S_EXEC, including HALT. It wraps modulo 2^CNT_W.
- Next-PC priority, highest first:
  1. done: go to S_HALT, pc unchanged, halted<=1.
  2. jump with instr[31:26]==0 and instr[5:0]==8 (JR): target=rs_data.
  3. jump otherwise (J/JAL): target={pc_plus4[31:28], instr[25:0], 2'b00}.
  4. branch && branch_cond: target=pc_plus4 + (sign_extend(instr[15:0])<<2), computed modulo 2^32.
  5. Otherwise: pc_plus4, modulo 2^32, so 0xFFFFFFFC wraps to 0.
- Misaligned targets:
  - The loaded pc always has bits [1:0] forced to 00.
  - If the selected target had non-zero bits [1:0], pc_misalign<=1 (sticky).
- After a non-halt S_EXEC: pc<=target, then go to S_FETCH.
- Fetch latency: minimum 2 cycles per instruction (imem_ready in the first S_FETCH cycle). Each cycle imem_ready is low adds one cycle.
- S_HALT:
  - imem_req=0 and instr_valid=0.
  - All registers are frozen.
  - Only rst leaves this state.
- Reset mid-operation: rst wins over every transition in the same edge. A late imem_ready from an aborted fetch is never accepted, because rst holds req low during the reset cycle.
- pc_plus4 is combinational from pc.

Decomposition:
- Shared package mips_pkg holds:
  - OP_RTYPE=6'd0, FUNC_JR=6'd8, OP_J=6'd2, OP_JAL=6'd3, OP_HALT=6'd63.
  - The fetch state enum.
  - The default RESET_PC.
- Sub-module next_pc_logic: purely combinational. Inputs are pc_plus4, instr, rs_data, branch, branch_cond and jump; outputs are target and misaligned. This keeps the target arithmetic independently testable.

Test Plan:
- Reset, then rdata=0x20080005 with ready in the first fetch cycle -> imem_addr=0, instr_valid pulses on cycle 2 with instr=0x20080005, pc_plus4=4; the next imem_addr=4; retired=1.
- pc=0x10, instr=0x1109FFFE (BEQ, imm=-2), branch=1, branch_cond=1 -> next imem_addr=0x0C; the same test with branch_cond=0 -> 0x14.
- pc=0x40000010, instr=0x08000100 (J), jump=1 -> next imem_addr=0x40000400. Same instruction with branch=1 and branch_cond=1 also asserted -> still 0x40000400 (jump priority).
- instr=0x03E00008 (JR), jump=1, rs_data=0x00000123 -> next imem_addr=0x00000120 and pc_misalign=1 from then on.
- imem_ready held low for 3 cycles -> imem_addr stable, instr_valid=0, retired unchanged; the instruction issues on the cycle after ready.
- instr=0xFC000000 with done=1 -> halted=1; for the next 10 cycles imem_req=0, instr_valid=0, pc frozen, retired frozen. Assert rst for 1 cycle -> pc=RESET_PC, halted=0, fetch resumes.
